// File: rtl/dsp_pkg.sv
// Shared DSP-slice constants and elaboration-time helpers.
// Holds the legal parameter ranges of the pipeline blocks and the width
// helper used to size occupancy counters.
package dsp_pkg;

    localparam int WIDTH_MIN = 32'sd1;
    localparam int WIDTH_MAX = 32'sd48;
    localparam int DEPTH_MIN = 32'sd0;
    localparam int DEPTH_MAX = 32'sd8;

    // Ceiling log2; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 32'sd1) begin
            result = result + 32'sd1;
        end
        return result;
    endfunction

    // Width of a counter able to hold 0..depth, never narrower than one bit.
    function automatic int occ_width(input int depth);
        int w;
        w = clog2(depth + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic pipeline stage: a data word plus its valid bit.
// Synchronous clear wins over load; with neither, the stage holds.
module elastic_stage #(
    parameter int WIDTH = 18
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             load,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out
);

    logic [WIDTH-1:0] data_r;
    logic             valid_r;

    // Stage register: reset/clear empty it, load captures the upstream slot.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (clr) begin
            data_r  <= '0;
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= d_in;
            valid_r <= v_in;
        end else begin
            data_r  <= data_r;
            valid_r <= valid_r;
        end
    end

    assign d_out = data_r;
    assign v_out = valid_r;

endmodule

// File: rtl/elastic_pipeline_reg.sv
// Elastic valid/ready pipeline register with bubble collapsing.
// DEPTH stages of elastic_stage; stage 0 faces the input. A stage advances
// whenever some stage at or beyond it is empty or the output is draining,
// so gaps close up and a full pipe still moves one word per cycle.
// DEPTH=0 or BYPASS=1 turns the block into a plain wire path.
module elastic_pipeline_reg
    import dsp_pkg::*;
#(
    parameter int WIDTH  = 18,
    parameter int DEPTH  = 2,
    parameter int BYPASS = 0
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         CE,
    input  logic                         SCLR,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int OCC_W = occ_width(DEPTH);

    generate
        if ((DEPTH == 0) || (BYPASS == 1)) begin : g_bypass

            // Control inputs have no meaning on a wire path.
            logic unused_s;
            assign unused_s  = ^{CLK, RSTN, CE, SCLR};

            assign out_data  = in_data;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign occupancy = {OCC_W{1'b0}};

        end else begin : g_pipe

            logic [DEPTH-1:0] load_s;
            logic [DEPTH-1:0] valid_s;
            logic [WIDTH-1:0] data_s [DEPTH];
            logic             go_s;
            logic             clr_s;
            logic             in_ready_s;
            logic             out_valid_s;
            logic             in_fire_s;
            logic             out_fire_s;
            logic [OCC_W-1:0] occ_r;

            // Advance enables: scan from the output back, a stage loads once a hole or a drain lies ahead.
            always_comb begin
                go_s   = out_ready;
                load_s = '0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    go_s      = go_s | ~valid_s[i];
                    load_s[i] = CE & go_s;
                end
            end

            assign clr_s       = CE & SCLR;
            assign in_ready_s  = RSTN & ~SCLR & load_s[0];
            assign out_valid_s = CE & valid_s[DEPTH-1];
            assign in_fire_s   = in_valid & in_ready_s;
            assign out_fire_s  = out_valid_s & out_ready;

            for (genvar i = 0; i < DEPTH; i++) begin : g_stage
                logic [WIDTH-1:0] d_in_s;
                logic             v_in_s;

                if (i == 0) begin : g_head
                    assign d_in_s = in_data;
                    assign v_in_s = in_valid;
                end else begin : g_link
                    assign d_in_s = data_s[i-1];
                    assign v_in_s = valid_s[i-1];
                end

                elastic_stage #(
                    .WIDTH (WIDTH)
                ) u_stage (
                    .CLK   (CLK),
                    .RSTN  (RSTN),
                    .load  (load_s[i]),
                    .clr   (clr_s),
                    .d_in  (d_in_s),
                    .v_in  (v_in_s),
                    .d_out (data_s[i]),
                    .v_out (valid_s[i])
                );
            end

            // Occupancy counter: +1 per accepted word, -1 per emitted word.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    occ_r <= '0;
                end else if (clr_s) begin
                    occ_r <= '0;
                end else begin
                    case ({in_fire_s, out_fire_s})
                        2'b10:   occ_r <= occ_r + OCC_W'(1'b1);
                        2'b01:   occ_r <= occ_r - OCC_W'(1'b1);
                        default: occ_r <= occ_r;
                    endcase
                end
            end

            assign in_ready  = in_ready_s;
            assign out_valid = out_valid_s;
            assign out_data  = data_s[DEPTH-1];
            assign occupancy = occ_r;

        end
    endgenerate

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Bench for elastic_pipeline_reg: three registered instances (DEPTH 2/3/4)
// and two wire-path instances share one stimulus stream. Each registered
// instance is tracked by a word-queue reference model in which every word
// carries its stage position and moves forward unless the word ahead blocks it.
module tb_elastic_pipeline_reg;

    localparam int W  = 18;
    localparam int NM = 3;

    logic         CLK = 1'b0;
    logic         RSTN;
    logic         CE;
    logic         SCLR;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] in_data;

    logic [W-1:0] od_a  [NM];
    logic         ov_a  [NM];
    logic         ir_a  [NM];
    logic [3:0]   occ_a [NM];
    logic [1:0]   occ2_s;
    logic [1:0]   occ3_s;
    logic [2:0]   occ4_s;

    logic [W-1:0] byp_od_s;
    logic         byp_ov_s;
    logic         byp_ir_s;
    logic [1:0]   byp_occ_s;
    logic [W-1:0] z_od_s;
    logic         z_ov_s;
    logic         z_ir_s;
    logic [0:0]   z_occ_s;

    // Reference model: per instance, words in order (index 0 oldest) with stage positions.
    logic [W-1:0] m_d     [NM][8];
    int           m_p     [NM][8];
    int           m_np    [NM][8];
    int           m_n     [NM];
    int           m_start [NM];
    logic         m_ir    [NM];

    int n_tests = 0;
    int n_fail  = 0;

    // Free-running clock, 10 time-unit period.
    always #5 CLK = ~CLK;

    elastic_pipeline_reg #(.WIDTH(W), .DEPTH(2), .BYPASS(0)) u_d2 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .SCLR(SCLR),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_a[0]),
        .out_data(od_a[0]), .out_valid(ov_a[0]), .out_ready(out_ready),
        .occupancy(occ2_s));

    elastic_pipeline_reg #(.WIDTH(W), .DEPTH(3), .BYPASS(0)) u_d3 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .SCLR(SCLR),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_a[1]),
        .out_data(od_a[1]), .out_valid(ov_a[1]), .out_ready(out_ready),
        .occupancy(occ3_s));

    elastic_pipeline_reg #(.WIDTH(W), .DEPTH(4), .BYPASS(0)) u_d4 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .SCLR(SCLR),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir_a[2]),
        .out_data(od_a[2]), .out_valid(ov_a[2]), .out_ready(out_ready),
        .occupancy(occ4_s));

    elastic_pipeline_reg #(.WIDTH(W), .DEPTH(2), .BYPASS(1)) u_byp (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .SCLR(SCLR),
        .in_data(in_data), .in_valid(in_valid), .in_ready(byp_ir_s),
        .out_data(byp_od_s), .out_valid(byp_ov_s), .out_ready(out_ready),
        .occupancy(byp_occ_s));

    elastic_pipeline_reg #(.WIDTH(W), .DEPTH(0), .BYPASS(0)) u_d0 (
        .CLK(CLK), .RSTN(RSTN), .CE(CE), .SCLR(SCLR),
        .in_data(in_data), .in_valid(in_valid), .in_ready(z_ir_s),
        .out_data(z_od_s), .out_valid(z_ov_s), .out_ready(out_ready),
        .occupancy(z_occ_s));

    assign occ_a[0] = {2'b00, occ2_s};
    assign occ_a[1] = {2'b00, occ3_s};
    assign occ_a[2] = {1'b0, occ4_s};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string why);
        for (int m = 0; m < NM; m++) begin
            check_eq($sformatf("%s.d%0d.occupancy", why, m + 2), 32'(occ_a[m]), 32'd0);
            check_eq($sformatf("%s.d%0d.out_valid", why, m + 2), 32'(ov_a[m]), 32'd0);
            check_eq($sformatf("%s.d%0d.in_ready", why, m + 2), 32'(ir_a[m]), 32'd0);
            check_eq($sformatf("%s.d%0d.out_data", why, m + 2), 32'(od_a[m]), 32'd0);
        end
    endtask

    // Compare every DUT against the model for the current inputs and plan the next move.
    task automatic model_check();
        for (int m = 0; m < NM; m++) begin
            int   dep;
            int   lim;
            logic e_ov;
            logic e_ir;
            logic slot0_free;
            dep  = m + 2;
            e_ov = CE && RSTN && (m_n[m] > 0) && (m_p[m][0] == dep - 1);
            check_eq($sformatf("d%0d.occupancy", dep), 32'(occ_a[m]), 32'(m_n[m]));
            check_eq($sformatf("d%0d.out_valid", dep), 32'(ov_a[m]), 32'(e_ov));
            if (e_ov) begin
                check_eq($sformatf("d%0d.out_data", dep), 32'(od_a[m]), 32'(m_d[m][0]));
            end
            m_start[m] = (e_ov && out_ready) ? 1 : 0;
            for (int k = m_start[m]; k < m_n[m]; k++) begin
                if (!CE) begin
                    m_np[m][k] = m_p[m][k];
                end else begin
                    lim = (k == m_start[m]) ? dep - 1 : m_np[m][k-1] - 1;
                    m_np[m][k] = (m_p[m][k] + 1 < lim) ? m_p[m][k] + 1 : lim;
                end
            end
            if (m_n[m] - m_start[m] == 0) slot0_free = 1'b1;
            else slot0_free = (m_np[m][m_n[m]-1] > 0);
            e_ir = RSTN && CE && !SCLR && slot0_free;
            m_ir[m] = e_ir;
            check_eq($sformatf("d%0d.in_ready", dep), 32'(ir_a[m]), 32'(e_ir));
        end
        check_eq("byp.out_data", 32'(byp_od_s), 32'(in_data));
        check_eq("byp.out_valid", 32'(byp_ov_s), 32'(in_valid));
        check_eq("byp.in_ready", 32'(byp_ir_s), 32'(out_ready));
        check_eq("byp.occupancy", 32'(byp_occ_s), 32'd0);
        check_eq("d0.out_data", 32'(z_od_s), 32'(in_data));
        check_eq("d0.out_valid", 32'(z_ov_s), 32'(in_valid));
        check_eq("d0.in_ready", 32'(z_ir_s), 32'(out_ready));
        check_eq("d0.occupancy", 32'(z_occ_s), 32'd0);
    endtask

    // Apply the planned move: drop the emitted word, advance, append the accepted word.
    task automatic model_commit();
        for (int m = 0; m < NM; m++) begin
            int k2;
            if (!RSTN) begin
                m_n[m] = 0;
            end else if (CE) begin
                if (SCLR) begin
                    m_n[m] = 0;
                end else begin
                    k2 = 0;
                    for (int k = m_start[m]; k < m_n[m]; k++) begin
                        m_d[m][k2] = m_d[m][k];
                        m_p[m][k2] = m_np[m][k];
                        k2++;
                    end
                    if (m_ir[m] && in_valid) begin
                        m_d[m][k2] = in_data;
                        m_p[m][k2] = 0;
                        k2++;
                    end
                    m_n[m] = k2;
                end
            end
        end
    endtask

    task automatic cyc_check();
        @(negedge CLK);
        model_check();
    endtask

    task automatic cyc_commit();
        model_commit();
        @(posedge CLK);
        #1;
    endtask

    task automatic cyc();
        cyc_check();
        cyc_commit();
    endtask

    task automatic drain(input int n);
        CE = 1'b1; SCLR = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (n) cyc();
    endtask

    task automatic fill(input int n, input int base);
        CE = 1'b1; SCLR = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        for (int c = 0; c < n; c++) begin
            in_data = W'(base + c);
            cyc();
        end
    endtask

    initial begin
        RSTN = 1'b0; CE = 1'b1; SCLR = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        for (int m = 0; m < NM; m++) m_n[m] = 0;
        #3;
        check_zero("reset");
        cyc();
        cyc();
        RSTN = 1'b1;

        // Three words back to back into an idle pipe.
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_data  = W'(c + 1);
            cyc_check();
            if (c == 2) check_eq("d2.occ_peak", 32'(occ2_s), 32'd2);
            if (c >= 2 && c <= 4) begin
                check_eq("d2.seq_valid", 32'(ov_a[0]), 32'd1);
                check_eq("d2.seq_data", 32'(od_a[0]), 32'(c - 1));
            end
            cyc_commit();
        end
        drain(6);

        // Stalled output: DEPTH=3 takes exactly three words, then drains in order.
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = W'(32'h100 + c);
            cyc_check();
            if (c >= 3) begin
                check_eq("d3.full_ready", 32'(ir_a[1]), 32'd0);
                check_eq("d3.full_occ", 32'(occ3_s), 32'd3);
            end
            cyc_commit();
        end
        drain(7);

        // Full DEPTH=2 pipe streaming one in / one out.
        fill(3, 32'h200);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = W'(32'h300 + c);
            cyc_check();
            check_eq("d2.stream_occ", 32'(occ2_s), 32'd2);
            check_eq("d2.stream_ready", 32'(ir_a[0]), 32'd1);
            check_eq("d2.stream_valid", 32'(ov_a[0]), 32'd1);
            cyc_commit();
        end
        drain(7);

        // Clock-enable freeze with three words held; SCLR pulses must be ignored.
        fill(3, 32'h400);
        CE = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            SCLR     = (c % 2 == 1);
            cyc_check();
            check_eq("d4.freeze_occ", 32'(occ4_s), 32'd3);
            check_eq("d4.freeze_ready", 32'(ir_a[2]), 32'd0);
            check_eq("d4.freeze_valid", 32'(ov_a[2]), 32'd0);
            cyc_commit();
        end
        drain(7);

        // Synchronous clear with an input offered in the same cycle.
        fill(2, 32'h500);
        SCLR = 1'b1; in_valid = 1'b1; in_data = W'(32'h5FF);
        cyc_check();
        check_eq("d4.sclr_ready", 32'(ir_a[2]), 32'd0);
        cyc_commit();
        SCLR = 1'b0; in_valid = 1'b0;
        cyc_check();
        check_eq("d4.sclr_occ", 32'(occ4_s), 32'd0);
        check_eq("d4.sclr_valid", 32'(ov_a[2]), 32'd0);
        cyc_commit();

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = W'(32'h600 + c);
            cyc();
        end
        RSTN = 1'b0;
        #1;
        check_zero("async_rst");
        for (int m = 0; m < NM; m++) m_n[m] = 0;
        cyc();
        RSTN = 1'b1;
        in_data = W'(32'h7AA);
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc_check();
        check_eq("d2.post_rst_data", 32'(od_a[0]), 32'h7AA);
        cyc_commit();
        drain(6);

        // Wire path with a constant word and a toggling downstream ready.
        in_data = W'(32'h2A); in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            out_ready = 1'(c % 2);
            cyc_check();
            check_eq("byp.const_data", 32'(byp_od_s), 32'h2A);
            check_eq("byp.mirror_ready", 32'(byp_ir_s), 32'(c % 2));
            cyc_commit();
        end
        drain(6);

        // Randomised traffic with occasional freezes and clears.
        for (int c = 0; c < 400; c++) begin
            CE        = ($urandom_range(0, 9) != 0);
            SCLR      = ($urandom_range(0, 49) == 0);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            cyc();
        end
        drain(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
